// File: rtl/bitread_pkg.sv
// bitread_pkg: shared types/constants for the bit-read
// driver and the arbiter-side checks.
package bitread_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    HOLDOFF
  } bitread_state_t;

  localparam int BITREAD_ADDR_W = 16;

  // Cycles the arbiter keeps its selector live after release
  localparam int BITREAD_HOLDOFF_CYCLES = 2;
  localparam int BITREAD_HOLD_W =
    $clog2(BITREAD_HOLDOFF_CYCLES + 1);

endpackage

// File: rtl/bitread_timeout_counter.sv
// bitread_timeout_counter: wait-for-ack cycle counter.
// Ports: CLK, RST, clear, enable -> terminal (count==LIMIT-1).
module bitread_timeout_counter #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/bitread_driver.sv
// bitread_driver: per-core single-bit read requester in front
// of the bit-read arbiter. Core side: REQ/ADDR/READY in,
// VALID/DATA/ERR out. Arbiter side: READ_REQUEST/ARB_ADDR out,
// ARB_ACK/ARB_DATA in. Optional wait-for-ack timeout under
// macro BITREAD_DRIVER_TIMEOUT_EN (ERR tied 0 without it).
module bitread_driver
  import bitread_pkg::*;
#(
  parameter int ADDR_W         = BITREAD_ADDR_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              READDRIVER_CORE_REQ,
  input  logic [ADDR_W-1:0] READDRIVER_CORE_ADDR,
  output logic              READDRIVER_CORE_READY,
  output logic              READDRIVER_CORE_VALID,
  output logic              READDRIVER_CORE_DATA,
  output logic              READDRIVER_CORE_ERR,
  output logic              READDRIVER_READ_REQUEST,
  output logic [ADDR_W-1:0] READDRIVER_ARB_ADDR,
  input  logic              READDRIVER_ARB_ACK,
  input  logic              READDRIVER_ARB_DATA
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535)
  begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..65535");
  end

  bitread_state_t              state;
  logic [BITREAD_HOLD_W-1:0]   hold_cnt;
  logic                        to_hit;

`ifdef BITREAD_DRIVER_TIMEOUT_EN
  logic accept;
  logic wait_en;

  assign accept  = (state == IDLE) &&
                   READDRIVER_CORE_REQ;
  assign wait_en = (state == WAIT_ACK) &&
                   !READDRIVER_ARB_ACK;

  bitread_timeout_counter #(
    .WIDTH (16),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (accept),
    .enable   (wait_en),
    .terminal (to_hit)
  );
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state                   <= IDLE;
      hold_cnt                <= '0;
      READDRIVER_CORE_READY   <= 1'b1;
      READDRIVER_CORE_VALID   <= 1'b0;
      READDRIVER_CORE_DATA    <= 1'b0;
      READDRIVER_CORE_ERR     <= 1'b0;
      READDRIVER_READ_REQUEST <= 1'b0;
      READDRIVER_ARB_ADDR     <= '0;
    end else begin
      READDRIVER_CORE_VALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (READDRIVER_CORE_REQ) begin
            READDRIVER_ARB_ADDR     <= READDRIVER_CORE_ADDR;
            READDRIVER_READ_REQUEST <= 1'b1;
            READDRIVER_CORE_READY   <= 1'b0;
            state                   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // ACK takes priority over a same-cycle timeout
          if (READDRIVER_ARB_ACK) begin
            READDRIVER_CORE_DATA    <= READDRIVER_ARB_DATA;
            READDRIVER_CORE_ERR     <= 1'b0;
            READDRIVER_CORE_VALID   <= 1'b1;
            READDRIVER_READ_REQUEST <= 1'b0;
            hold_cnt <=
              BITREAD_HOLD_W'(BITREAD_HOLDOFF_CYCLES);
            state    <= HOLDOFF;
          end else if (to_hit) begin
            READDRIVER_CORE_DATA    <= 1'b0;
            READDRIVER_CORE_ERR     <= 1'b1;
            READDRIVER_CORE_VALID   <= 1'b1;
            READDRIVER_READ_REQUEST <= 1'b0;
            hold_cnt <=
              BITREAD_HOLD_W'(BITREAD_HOLDOFF_CYCLES);
            state    <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          // Arbiter may still drive stale ACK and address
          // selection here; ACK ignored, ARB_ADDR frozen.
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == BITREAD_HOLD_W'(1)) begin
            state                 <= IDLE;
            READDRIVER_CORE_READY <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitread_driver.sv
// tb_bitread_driver: random reads against an arbiter model,
// scoreboard queue checked by a VALID monitor.
module tb_bitread_driver;

  localparam int AW = 16;
  localparam int TO = 8;
`ifdef BITREAD_DRIVER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CORE_REQ = 1'b0;
  logic [AW-1:0] CORE_ADDR = '0;
  logic          CORE_READY;
  logic          CORE_VALID;
  logic          CORE_DATA;
  logic          CORE_ERR;
  logic          READ_REQUEST;
  logic [AW-1:0] ARB_ADDR;
  logic          ARB_ACK = 1'b0;
  logic          ARB_DATA = 1'b0;

  always #5 CLK = ~CLK;

  bitread_driver #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK                     (CLK),
    .RST                     (RST),
    .READDRIVER_CORE_REQ     (CORE_REQ),
    .READDRIVER_CORE_ADDR    (CORE_ADDR),
    .READDRIVER_CORE_READY   (CORE_READY),
    .READDRIVER_CORE_VALID   (CORE_VALID),
    .READDRIVER_CORE_DATA    (CORE_DATA),
    .READDRIVER_CORE_ERR     (CORE_ERR),
    .READDRIVER_READ_REQUEST (READ_REQUEST),
    .READDRIVER_ARB_ADDR     (ARB_ADDR),
    .READDRIVER_ARB_ACK      (ARB_ACK),
    .READDRIVER_ARB_DATA     (ARB_DATA)
  );

  bit mem [0:65535];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Arbiter model: grant after tok_delay cycles of
  // registered request, ACK lingers stale_n cycles
  // after release.
  int tok_delay = 1;
  int stale_n   = 0;
  int a_wcnt    = 0;
  int a_hold    = 0;

  always @(posedge CLK) begin
    if (RST) begin
      ARB_ACK  <= 1'b0;
      ARB_DATA <= 1'b0;
      a_wcnt   <= 0;
      a_hold   <= 0;
    end else if (READ_REQUEST) begin
      if (a_wcnt < tok_delay) begin
        a_wcnt <= a_wcnt + 1;
      end else begin
        ARB_ACK  <= 1'b1;
        ARB_DATA <= mem[ARB_ADDR];
      end
      a_hold <= stale_n;
    end else begin
      a_wcnt <= 0;
      if (a_hold > 0) a_hold <= a_hold - 1;
      else ARB_ACK <= 1'b0;
    end
  end

  typedef struct {
    bit            data;
    bit            err;
    int            lat;
    int            acc;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          q[$];
  int            cyc      = 0;
  int            n_acc    = 0;
  logic [AW-1:0] cur_addr = '0;

  // Accept side: expected response from the read rules
  always @(posedge CLK) begin
    exp_t e;
    cyc = cyc + 1;
    if (RST) begin
      q.delete();
    end else if (CORE_READY && CORE_REQ) begin
      e.err  = TO_EN && (tok_delay + 2 > TO);
      e.data = e.err ? 1'b0 : mem[CORE_ADDR];
      e.lat  = e.err ? TO : tok_delay + 2;
      e.acc  = cyc;
      e.addr = CORE_ADDR;
      q.push_back(e);
      cur_addr = CORE_ADDR;
      n_acc    = n_acc + 1;
    end
  end

  bit prev_valid = 1'b0;
  bit last_data  = 1'b0;
  int rdy_cd     = 0;
  int addr_cd    = 0;

  // Response monitor
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      prev_valid = 1'b0;
      last_data  = 1'b0;
      rdy_cd     = 0;
      addr_cd    = 0;
    end else begin
      if (CORE_VALID) begin
        chk("valid_gap", prev_valid, 1'b0);
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("data", CORE_DATA, e.data);
          chk("err", CORE_ERR, e.err);
          chk("latency", cyc - e.acc, e.lat);
        end
        chk("ready_busy", CORE_READY, 1'b0);
        last_data = CORE_DATA;
        rdy_cd    = 2;
        addr_cd   = 2;
      end else begin
        chk("data_hold", CORE_DATA, last_data);
        if (rdy_cd > 0) begin
          rdy_cd--;
          chk("ready_ret", CORE_READY, rdy_cd == 0);
        end
      end
      if (READ_REQUEST || addr_cd > 0)
        chk("arb_addr", ARB_ADDR, cur_addr);
      if (addr_cd > 0) addr_cd--;
      prev_valid = CORE_VALID;
    end
  end

  task automatic do_read(input logic [AW-1:0] a,
                         input int d, input int s,
                         input bit keep);
    int start;
    bit got;
    @(negedge CLK);
    tok_delay = d;
    stale_n   = s;
    CORE_ADDR = a;
    CORE_REQ  = 1'b1;
    start     = n_acc;
    got       = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      got = (n_acc != start);
    end
    if (!got) chk("accept_timeout", 0, 1);
    if (!keep) CORE_REQ = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge CLK);
      got = (q.size() == 0);
    end
    if (!got) chk("response_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int start;
    bit got;
    for (int i = 0; i < 65536; i++)
      mem[i] = 1'($urandom_range(0, 1));
    mem[16'h1234] = 1'b1;
    mem[16'h0001] = 1'b0;
    mem[16'h0002] = 1'b1;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", CORE_READY, 1'b1);
    chk("rst_valid", CORE_VALID, 1'b0);
    chk("rst_data", CORE_DATA, 1'b0);
    chk("rst_err", CORE_ERR, 1'b0);
    chk("rst_req", READ_REQUEST, 1'b0);
    chk("rst_addr", ARB_ADDR, 16'h0);
    @(negedge CLK);
    RST = 1'b0;

    do_read(16'h1234, 1, 0, 1'b0);
    do_read(16'h5555, 1, 2, 1'b0);
    do_read(16'h0001, 1, 1, 1'b1);
    do_read(16'h0002, 1, 2, 1'b0);
    do_read(16'h0abc, 50, 1, 1'b0);
    do_read(16'h0111, TO - 2, 2, 1'b0);
    do_read(16'h0222, TO - 1, 0, 1'b0);
    do_read(16'h0333, TO + 4, 2, 1'b0);

    for (int n = 0; n < 40; n++)
      do_read(AW'($urandom),
              $urandom_range(1, 12),
              $urandom_range(0, 2),
              (n != 39) && ($urandom_range(0, 1) == 1));
    CORE_REQ = 1'b0;

    // Reset one cycle into WAIT_ACK
    @(negedge CLK);
    tok_delay = 20;
    stale_n   = 0;
    CORE_ADDR = 16'h4321;
    CORE_REQ  = 1'b1;
    start     = n_acc;
    got       = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge CLK);
      got = (n_acc != start);
    end
    if (!got) chk("accept_timeout", 0, 1);
    CORE_REQ = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("mid_rst_req", READ_REQUEST, 1'b0);
    chk("mid_rst_ready", CORE_READY, 1'b1);
    chk("mid_rst_valid", CORE_VALID, 1'b0);
    chk("mid_rst_data", CORE_DATA, 1'b0);
    chk("mid_rst_err", CORE_ERR, 1'b0);
    chk("mid_rst_addr", ARB_ADDR, 16'h0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (30) @(negedge CLK);
    chk("mid_rst_queue", q.size(), 0);
    do_read(16'h1234, 2, 1, 1'b0);

    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
